// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : 5-stage pipeline controller. Merges per-stage stall requests
//             into the stall[5:0] vector, sequences exception/ERET redirects
//             (1-cycle flush + new_pc), enforces a post-flush settle window
//             and keeps saturating stall/flush performance counters.
//  Option   : PIPE_CTRL_WDT_EN - EX-hold watchdog that forces a redirect to
//             EXC_VECTOR after WDT_LIMIT consecutive EX/MEM hold cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          CNT_W         = 16,
  parameter int          WDT_LIMIT     = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             wdt_fire_o
);

  localparam int              SC_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_INIT   = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0]     ERET_CODE = 32'h0000_000e;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t           r_state;
  logic [SC_W-1:0]  r_settle_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic [5:0]  w_stall_dec;
  logic        w_exc_valid;
  logic        w_wdt_hit;
  logic        w_flush;
  logic [31:0] w_new_pc;

  // Priority stall decode: the deepest requesting stage freezes itself and everything upstream
  always_comb begin
    w_stall_dec = 6'b000000;
    if (stallreq_mem)     w_stall_dec = 6'b011111;
    else if (stallreq_ex) w_stall_dec = 6'b001111;
    else if (stallreq_id) w_stall_dec = 6'b000111;
    else if (stallreq_if) w_stall_dec = 6'b000011;
  end

  // Redirect decision; a real exception owns new_pc even when the watchdog trips together
  always_comb begin
    w_exc_valid = resetn && (excepttype_i != 32'd0) && (r_state == RUN);
    w_flush     = w_exc_valid || w_wdt_hit;
    w_new_pc    = 32'd0;
    if (w_exc_valid)
      w_new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    else if (w_wdt_hit)
      w_new_pc = EXC_VECTOR;
  end

  // Flush squashes any stall so the redirected fetch is not held; reset forces all quiet
  assign stall  = (w_flush || !resetn) ? 6'b000000 : w_stall_dec;
  assign flush  = w_flush;
  assign new_pc = w_new_pc;

  // RUN/SETTLE sequencing; the settle window always runs to completion regardless of stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= RUN;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_flush) begin
            r_state      <= SETTLE;
            r_settle_cnt <= SC_INIT;
          end
        end
        SETTLE: begin
          if (r_settle_cnt == '0) r_state <= RUN;
          else                    r_settle_cnt <= r_settle_cnt - SC_W'(1);
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Saturating performance counters: hold at all-ones instead of wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall[0] && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush && (r_flush_count != '1))   r_flush_count  <= r_flush_count + CNT_W'(1);
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_count_o  = r_flush_count;

`ifdef PIPE_CTRL_WDT_EN
  localparam int              WD_W    = $clog2(WDT_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WDT_LIMIT - 1);

  logic [WD_W-1:0] r_wdt_cnt;
  logic            r_wdt_fire;

  // Trip on the WDT_LIMIT-th consecutive EX hold; uses the pre-flush decode to avoid a loop
  assign w_wdt_hit = resetn && (r_state == RUN) && w_stall_dec[3] && (r_wdt_cnt >= WD_TRIP);

  // Consecutive EX/MEM-hold counter (saturates at the trip point) and sticky fire flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdt_cnt  <= '0;
      r_wdt_fire <= 1'b0;
    end else begin
      if (!stall[3] || w_flush)    r_wdt_cnt <= '0;
      else if (r_wdt_cnt != WD_TRIP) r_wdt_cnt <= r_wdt_cnt + WD_W'(1);
      if (w_wdt_hit) r_wdt_fire <= 1'b1;
    end
  end

  assign wdt_fire_o = r_wdt_fire;
`else
  logic w_unused_wdt_limit;
  assign w_unused_wdt_limit = ^WDT_LIMIT;
  assign w_wdt_hit          = 1'b0;
  assign wdt_fire_o         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl (CNT_W=4, WDT_LIMIT=8).
//             A reference model predicts every cycle's outputs into a queue
//             when inputs are driven; each test pops and compares at negedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0020;
  localparam int          SETTLE  = 2;
  localparam int          WLIM    = 8;

  logic        clk;
  logic        resetn;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  stall_cycles_o, flush_count_o;
  logic        wdt_fire_o;

  pipe_ctrl #(
    .EXC_VECTOR   (EXC_VEC),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (4),
    .WDT_LIMIT    (WLIM)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cycles_o(stall_cycles_o),
    .flush_count_o (flush_count_o),
    .wdt_fire_o    (wdt_fire_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        wdt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // reference model state
  int   m_settle = 0;   // remaining settle cycles, 0 = RUN
  int   m_sc = 0, m_fc = 0, m_wcnt = 0;
  logic m_wfire = 1'b0;

  // Drive one cycle of inputs and push the model's prediction for this cycle.
  // req = {mem, ex, id, if}
  task automatic drive(input logic rn, input logic [3:0] req,
                       input logic [31:0] exc, input logic [31:0] epc);
    exp_t       x;
    logic [5:0] dec;
    logic       excv, wdth, fl;
    resetn       = rn;
    stallreq_if  = req[0];
    stallreq_id  = req[1];
    stallreq_ex  = req[2];
    stallreq_mem = req[3];
    excepttype_i = exc;
    cp0_epc_i    = epc;
    cyc++;
    if (!rn) begin
      m_settle = 0; m_sc = 0; m_fc = 0; m_wcnt = 0; m_wfire = 1'b0;
      x = '{6'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0};
      sb.push_back(x);
      return;
    end
    dec = req[3] ? 6'b011111 : req[2] ? 6'b001111 : req[1] ? 6'b000111 :
          req[0] ? 6'b000011 : 6'b000000;
    excv = (exc != 32'd0) && (m_settle == 0);
`ifdef PIPE_CTRL_WDT_EN
    wdth = (m_settle == 0) && dec[3] && (m_wcnt >= WLIM - 1);
`else
    wdth = 1'b0;
`endif
    fl = excv || wdth;
    x.stall = fl ? 6'd0 : dec;
    x.flush = fl;
    x.pc    = excv ? ((exc == 32'he) ? epc : EXC_VEC) : (wdth ? EXC_VEC : 32'd0);
    x.sc    = 4'(m_sc);
    x.fc    = 4'(m_fc);
    x.wdt   = m_wfire;
    sb.push_back(x);
    if (x.stall[0] && m_sc < 15) m_sc++;
    if (fl && m_fc < 15) m_fc++;
    if (wdth) m_wfire = 1'b1;
    m_wcnt = (!x.stall[3] || fl) ? 0 : m_wcnt + 1;
    if (m_settle == 0) begin
      if (fl) m_settle = SETTLE;
    end else begin
      m_settle--;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b0, 4'(i * 5 + 3), 32'h8, 32'h1234);
      else       drive(1'b1, 4'(1 << (i - 4)), 32'h0, 32'h0);
      @(negedge clk); e = sb.pop_front();
      n_cmp++;
      if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
        n_err++;
        $display("FAIL reset cyc%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                 cyc, stall, flush, new_pc, e.stall, e.flush, e.pc);
      end
      n_cmp++;
      if ({stall_cycles_o, flush_count_o, wdt_fire_o} !== {e.sc, e.fc, e.wdt}) begin
        n_err++;
        $display("FAIL reset_cnt cyc%0d: got sc=%h fc=%h wdt=%b, want sc=%h fc=%h wdt=%b",
                 cyc, stall_cycles_o, flush_count_o, wdt_fire_o, e.sc, e.fc, e.wdt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_decode();
    logic [3:0] pat [8] = '{4'b1010, 4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b1111, 4'b0011, 4'b0000};
    drive(1'b0, 4'b0, 32'h0, 32'h0);
    void'(sb.pop_front());
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat[i], 32'h0, 32'h0);
      @(negedge clk); e = sb.pop_front();
      n_cmp++;
      if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
        n_err++;
        $display("FAIL stall_decode req=%b: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                 pat[i], stall, flush, new_pc, e.stall, e.flush, e.pc);
      end
      n_cmp++;
      if ({stall_cycles_o, flush_count_o, wdt_fire_o} !== {e.sc, e.fc, e.wdt}) begin
        n_err++;
        $display("FAIL stall_count req=%b: got sc=%h fc=%h wdt=%b, want sc=%h fc=%h wdt=%b",
                 pat[i], stall_cycles_o, flush_count_o, wdt_fire_o, e.sc, e.fc, e.wdt);
      end
      @(posedge clk); #1;
    end
    // 6 of the 8 patterns request a stall
    n_cmp++;
    if (stall_cycles_o !== 4'd6) begin
      n_err++;
      $display("FAIL stall_total: got %0d want 6", stall_cycles_o);
    end
  endtask

  // Exception with EX stall, exception held through settle, then an ERET
  task automatic test_exception();
    logic [3:0]  req [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    logic [31:0] exc [7] = '{32'h8, 32'h8, 32'h8, 32'h0, 32'he, 32'h8, 32'h0};
    drive(1'b0, 4'b0, 32'h0, 32'h0);
    void'(sb.pop_front());
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, req[i], exc[i], 32'hBFC0_0100);
      @(negedge clk); e = sb.pop_front();
      n_cmp++;
      if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
        n_err++;
        $display("FAIL exception step%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                 i, stall, flush, new_pc, e.stall, e.flush, e.pc);
      end
      n_cmp++;
      if ({stall_cycles_o, flush_count_o, wdt_fire_o} !== {e.sc, e.fc, e.wdt}) begin
        n_err++;
        $display("FAIL exception_cnt step%0d: got sc=%h fc=%h wdt=%b, want sc=%h fc=%h wdt=%b",
                 i, stall_cycles_o, flush_count_o, wdt_fire_o, e.sc, e.fc, e.wdt);
      end
      if (i == 3) begin
        n_cmp++;
        if (flush_count_o !== 4'd1) begin
          n_err++;
          $display("FAIL exc_flush_once: got %0d want 1", flush_count_o);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted mid-SETTLE returns to RUN; an exception right after reset flushes
  task automatic test_reset_mid_settle();
    logic        rn  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exc [4] = '{32'h4, 32'h4, 32'h4, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(rn[i], 4'b0001, exc[i], 32'h0);
      @(negedge clk); e = sb.pop_front();
      n_cmp++;
      if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
        n_err++;
        $display("FAIL mid_settle step%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                 i, stall, flush, new_pc, e.stall, e.flush, e.pc);
      end
      n_cmp++;
      if ({stall_cycles_o, flush_count_o, wdt_fire_o} !== {e.sc, e.fc, e.wdt}) begin
        n_err++;
        $display("FAIL mid_settle_cnt step%0d: got sc=%h fc=%h wdt=%b, want sc=%h fc=%h wdt=%b",
                 i, stall_cycles_o, flush_count_o, wdt_fire_o, e.sc, e.fc, e.wdt);
      end
      @(posedge clk); #1;
    end
  endtask

  // 20 stall cycles then 18 flushes saturate both 4-bit counters at 4'hF
  task automatic test_saturation();
    for (int i = 0; i < 74; i++) begin
      if (i < 20)             drive(1'b1, 4'b0001, 32'h0, 32'h0);
      else if ((i % 3) == 2)  drive(1'b1, 4'b0000, 32'h8, 32'h0);
      else                    drive(1'b1, 4'b0000, 32'h0, 32'h0);
      @(negedge clk); e = sb.pop_front();
      n_cmp++;
      if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
        n_err++;
        $display("FAIL saturation step%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                 i, stall, flush, new_pc, e.stall, e.flush, e.pc);
      end
      n_cmp++;
      if ({stall_cycles_o, flush_count_o, wdt_fire_o} !== {e.sc, e.fc, e.wdt}) begin
        n_err++;
        $display("FAIL saturation_cnt step%0d: got sc=%h fc=%h wdt=%b, want sc=%h fc=%h wdt=%b",
                 i, stall_cycles_o, flush_count_o, wdt_fire_o, e.sc, e.fc, e.wdt);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({stall_cycles_o, flush_count_o} !== 8'hFF) begin
      n_err++;
      $display("FAIL saturated: got sc=%h fc=%h want F F", stall_cycles_o, flush_count_o);
    end
  endtask

  // EX stall held 12 cycles: watchdog build flushes on the 8th, default build never does
  task automatic test_watchdog();
    logic exp_fire;
`ifdef PIPE_CTRL_WDT_EN
    exp_fire = 1'b1;
`else
    exp_fire = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 15) drive(1'b0, 4'b0100, 32'h0, 32'h0);
      else if (i < 13)       drive(1'b1, 4'b0100, 32'h0, 32'h0);
      else                   drive(1'b1, 4'b0000, 32'h0, 32'h0);
      @(negedge clk); e = sb.pop_front();
      n_cmp++;
      if ({stall, flush, new_pc} !== {e.stall, e.flush, e.pc}) begin
        n_err++;
        $display("FAIL watchdog step%0d: got stall=%b flush=%b pc=%h, want stall=%b flush=%b pc=%h",
                 i, stall, flush, new_pc, e.stall, e.flush, e.pc);
      end
      n_cmp++;
      if ({stall_cycles_o, flush_count_o, wdt_fire_o} !== {e.sc, e.fc, e.wdt}) begin
        n_err++;
        $display("FAIL watchdog_cnt step%0d: got sc=%h fc=%h wdt=%b, want sc=%h fc=%h wdt=%b",
                 i, stall_cycles_o, flush_count_o, wdt_fire_o, e.sc, e.fc, e.wdt);
      end
      if (i == 14) begin
        n_cmp++;
        if (wdt_fire_o !== exp_fire) begin
          n_err++;
          $display("FAIL wdt_sticky: got %b want %b", wdt_fire_o, exp_fire);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    resetn       = 1'b0;
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_stall_decode();
    test_exception();
    test_reset_mid_settle();
    test_saturation();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
